seg7_scan_driver: RTL



---
 rtl/seg7_pkg.sv | 39 +++
 rtl/seg7_decode.sv | 38 +++
 rtl/seg7_scan_driver.sv | 136 +++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// ============================================================================
// Module : seg7_pkg
// Shared digit codes, segment patterns and scan FSM encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package seg7_pkg;

    // Digit codes shared with the display controller
    localparam logic [3:0] CODE_OFF  = 4'd10;
    localparam logic [3:0] CODE_P    = 4'd11;
    localparam logic [3:0] CODE_DASH = 4'd12;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, 1 = lit
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_P     = 7'b1110011;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;

    typedef enum logic [1:0] {
        ST_TENS_BLANK = 2'd0,
        ST_TENS_ON    = 2'd1,
        ST_ONES_BLANK = 2'd2,
        ST_ONES_ON    = 2'd3
    } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// ============================================================================
// Module : seg7_decode
// Combinational digit code to segment pattern, with a dark flag for off codes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg,
    output logic       o_dark
);

    always_comb begin
        o_seg  = SEG_BLANK;
        o_dark = 1'b0;
        case (i_code)
            4'd0:      o_seg = SEG_0;
            4'd1:      o_seg = SEG_1;
            4'd2:      o_seg = SEG_2;
            4'd3:      o_seg = SEG_3;
            4'd4:      o_seg = SEG_4;
            4'd5:      o_seg = SEG_5;
            4'd6:      o_seg = SEG_6;
            4'd7:      o_seg = SEG_7;
            4'd8:      o_seg = SEG_8;
            4'd9:      o_seg = SEG_9;
            CODE_P:    o_seg = SEG_P;
            CODE_DASH: o_seg = SEG_DASH;
            default:   o_dark = 1'b1;   // CODE_OFF and 13..15
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seg7_scan_driver.sv
// ============================================================================
// Module : seg7_scan_driver
// Two-digit multiplexed 7-segment driver with blanking and per-frame capture.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGIT_TICKS  = 4,
    parameter int BLANK_TICKS  = 1,
    parameter int COMMON_ANODE = 0
) (
    input  logic       clk_1khz,
    input  logic       rst_ni,
    input  logic [3:0] tens_i,
    input  logic [3:0] ones_i,
    input  logic       lz_blank_i,
    output logic [6:0] seg_o,
    output logic [1:0] dig_o,
    output logic       frame_o
);

    localparam int          CW          = $clog2(DIGIT_TICKS);
    localparam logic [CW-1:0] c_BLANK_LAST = CW'(BLANK_TICKS - 1);
    localparam logic [CW-1:0] c_SLOT_LAST  = CW'(DIGIT_TICKS - 1);
    localparam logic [6:0]  c_SEG_INV   = (COMMON_ANODE != 0) ? 7'h7F : 7'h00;
    localparam logic [1:0]  c_DIG_INV   = (COMMON_ANODE != 0) ? 2'b11 : 2'b00;

    generate
        if (BLANK_TICKS < 1 || BLANK_TICKS >= DIGIT_TICKS || DIGIT_TICKS < 2) begin : g_bad_timing
            $error("seg7_scan_driver: need 1 <= BLANK_TICKS < DIGIT_TICKS and DIGIT_TICKS >= 2");
        end
    endgenerate

    scan_state_t   r_state;
    logic [CW-1:0] r_cnt;
    logic          r_armed;
    logic [3:0]    r_tens_q;
    logic [3:0]    r_ones_q;
    logic          r_lz_q;

    scan_state_t   w_state_nx;
    logic [CW-1:0] w_cnt_nx;
    logic          w_capture;
    logic [3:0]    w_tens_nx;
    logic [3:0]    w_ones_nx;
    logic          w_lz_nx;
    logic [3:0]    w_dec_code;
    logic [6:0]    w_dec_seg;
    logic          w_dec_dark;
    logic          w_lit;
    logic [6:0]    w_seg_nx;
    logic [1:0]    w_dig_nx;
    logic          w_frame_nx;

    // The first edge after reset only arms the scanner, so the following
    // cycle is a full frame-start cycle with frame_o high.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + CW'(1);
        if (!r_armed) begin
            w_state_nx = ST_TENS_BLANK;
            w_cnt_nx   = '0;
        end else begin
            case (r_state)
                ST_TENS_BLANK: if (r_cnt == c_BLANK_LAST) w_state_nx = ST_TENS_ON;
                ST_ONES_BLANK: if (r_cnt == c_BLANK_LAST) w_state_nx = ST_ONES_ON;
                ST_TENS_ON: if (r_cnt == c_SLOT_LAST) begin
                    w_state_nx = ST_ONES_BLANK;
                    w_cnt_nx   = '0;
                end
                ST_ONES_ON: if (r_cnt == c_SLOT_LAST) begin
                    w_state_nx = ST_TENS_BLANK;
                    w_cnt_nx   = '0;
                end
                default: begin
                    w_state_nx = ST_TENS_BLANK;
                    w_cnt_nx   = '0;
                end
            endcase
        end
    end

    assign w_capture  = r_armed && (r_state == ST_TENS_BLANK) && (r_cnt == '0);
    assign w_tens_nx  = w_capture ? tens_i     : r_tens_q;
    assign w_ones_nx  = w_capture ? ones_i     : r_ones_q;
    assign w_lz_nx    = w_capture ? lz_blank_i : r_lz_q;
    assign w_dec_code = (w_state_nx == ST_TENS_ON) ? w_tens_nx : w_ones_nx;

    seg7_decode u_decode (
        .i_code (w_dec_code),
        .o_seg  (w_dec_seg),
        .o_dark (w_dec_dark)
    );

    // Outputs are computed from the next state so they register in step with it
    always_comb begin
        w_lit = 1'b0;
        if (w_state_nx == ST_TENS_ON)
            w_lit = !w_dec_dark && !(w_lz_nx && (w_tens_nx == 4'd0));
        else if (w_state_nx == ST_ONES_ON)
            w_lit = !w_dec_dark;
        w_seg_nx   = w_lit ? w_dec_seg : SEG_BLANK;
        w_dig_nx   = !w_lit ? 2'b00 : ((w_state_nx == ST_TENS_ON) ? 2'b10 : 2'b01);
        w_frame_nx = (w_state_nx == ST_TENS_BLANK) && (w_cnt_nx == '0);
    end

    always_ff @(posedge clk_1khz or negedge rst_ni) begin
        if (!rst_ni) begin
            r_armed  <= 1'b0;
            r_state  <= ST_TENS_BLANK;
            r_cnt    <= '0;
            r_tens_q <= CODE_OFF;
            r_ones_q <= CODE_OFF;
            r_lz_q   <= 1'b0;
            seg_o    <= c_SEG_INV;
            dig_o    <= c_DIG_INV;
            frame_o  <= 1'b0;
        end else begin
            r_armed  <= 1'b1;
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_tens_q <= w_tens_nx;
            r_ones_q <= w_ones_nx;
            r_lz_q   <= w_lz_nx;
            seg_o    <= w_seg_nx ^ c_SEG_INV;
            dig_o    <= w_dig_nx ^ c_DIG_INV;
            frame_o  <= w_frame_nx;
        end
    end

endmodule

`default_nettype wire
